receive_decoder: RTL and testbench
==================================

RECEIVE_DECODER -- requirements
Module: receive_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clk cycles per UART bit; legal range 4..1023.
REQ-002 SHALL have parameter IDLE_TIMEOUT_BITS, default 20, bit-times of line idle after a low byte before the pending low byte is discarded.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port serial_in  input  1  UART line, idle high, 8N1 (8E1 with RX_PARITY_EN), LSB first.
REQ-006 SHALL have port read_en  input  1  consumer acknowledges word_out this cycle.
REQ-007 SHALL have port word_out  output  16  assembled word {high byte, low byte}.
REQ-008 SHALL have port word_valid  output  1  word_out holds an unread word.
REQ-009 SHALL have port rx_active  output  1  a frame is in progress (state not IDLE).
REQ-010 SHALL have port frame_err  output  1  sticky; stop-bit or parity error seen.
REQ-011 SHALL have port overrun  output  1  sticky; a completed word was dropped.

Function
REQ-012 SHALL pass serial_in through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, with one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-014 IDLE -> START on synchronized line low; START waits (CLKS_PER_BIT-1)/2 cycles, then line low -> DATA, line high -> IDLE (glitch, no error).
REQ-015 DATA SHALL sample every CLKS_PER_BIT cycles, bit index 0..7 into shift register LSB first, then -> PARITY or STOP.
REQ-016 STOP SHALL sample once after CLKS_PER_BIT cycles and return to IDLE on the same edge; sample 0 sets frame_err, discards the byte, and resets byte phase to low.
REQ-017 Byte phase: first good byte stored as low byte; second good byte forms word {second, first}; phase then returns to low.
REQ-018 word_out and word_valid SHALL update on the clock edge after the STOP sample edge of the high byte (latency 1 cycle).
REQ-019 word_valid SHALL stay 1 until a cycle with read_en=1; cleared on that edge; read_en with word_valid=0 ignored.
REQ-020 New word with word_valid=1 and read_en=0 that cycle: word_out unchanged, new word discarded, overrun set.
REQ-021 New word in same cycle as read_en=1: word_out loads new word, word_valid stays 1, overrun unchanged.
REQ-022 frame_err and overrun SHALL clear on any read_en=1 edge unless set again on that same edge (set wins).
REQ-023 Low byte pending with line idle in IDLE for IDLE_TIMEOUT_BITS*CLKS_PER_BIT cycles SHALL discard it and reset byte phase; no flag.
REQ-024 rx_active SHALL be 1 in every state except IDLE.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counters 0, byte phase low, synchronizer 1, word_out 16'h0000, word_valid 0, rx_active 0, frame_err 0, overrun 0.
REQ-026 Reset mid-frame SHALL discard the partial frame and pending low byte; after release, reception restarts only on a new falling edge.

Configuration
REQ-027 Macro RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit after DATA; mismatch with even parity of data sets frame_err and discards byte as in REQ-016.
REQ-028 RX_PARITY_EN undefined: no PARITY state, no parity logic; DATA -> STOP directly; frame is 8N1.

Verification (CLKS_PER_BIT=4, IDLE_TIMEOUT_BITS=20)
REQ-029 Bytes 0x34 then 0x12, 8N1 -> word_out=16'h1234, word_valid=1 exactly 1 cycle after second STOP sample; flags 0.
REQ-030 Word 0xBEEF unread, then 0x0D,0xF0 sent, read_en held 0 -> word_out stays 16'hBEEF, overrun=1; one read_en pulse -> word_valid=0, overrun=0.
REQ-031 Low pulse of 1 cycle on serial_in -> returns to IDLE, no flags, no byte counted; next 0x55,0xAA -> 16'hAA55.
REQ-032 Byte 0x77 with stop bit 0, then 0x11,0x22 -> frame_err=1, word_out=16'h2211.
REQ-033 rst asserted mid-DATA after low byte 0x99 -> all outputs 0 at once; then 0x01,0x02 -> 16'h0201.
REQ-034 With RX_PARITY_EN: 0x03 with parity 1 -> frame_err=1, byte dropped; 0x03 with parity 0 accepted as low byte.

Source files
------------

// File: rtl/receive_decoder.sv
// rtl/receive_decoder.sv - UART receiver pairing two bytes into a 16-bit word; optional RX_PARITY_EN macro selects 8E1 framing
module receive_decoder #(
  parameter int CLKS_PER_BIT      = 87,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  input  logic        read_en,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        rx_active,
  output logic        frame_err,
  output logic        overrun
);

  localparam logic [9:0]  BIT_LAST  = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0]  HALF_LAST = 10'((CLKS_PER_BIT - 1) / 2);
  localparam logic [31:0] TO_LAST   = 32'(IDLE_TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  low_q;
  logic        phase_q;      // 1: a low byte is pending
  logic        arm_q;        // line has been seen high since entering IDLE
  logic [31:0] idle_cnt_q;
  logic        word_pend_q;
  logic [15:0] word_new_q;
  logic        frame_err_q;
  logic        s1_q, s2_q;
  logic [1:0]  warm_q;       // synchronizer holds real line data once warm_q[1] is set
  logic [15:0] word_out_q;
  logic        word_valid_q;
  logic        overrun_q;
  logic        rx;
  logic        byte_ok;

`ifdef RX_PARITY_EN
  logic        par_bad_q;
  assign byte_ok = rx && !par_bad_q;
`else
  assign byte_ok = rx;
`endif

  assign rx         = s2_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign rx_active  = (state_q != ST_IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  // Two-flop line synchronizer plus a warm-up marker so reset values never look like a real edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      warm_q <= 2'b00;
    end else begin
      s1_q   <= serial_in;
      s2_q   <= s1_q;
      warm_q <= {warm_q[0], 1'b1};
    end
  end

  // Frame FSM: bit timing, byte assembly, byte pairing, idle timeout and frame error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      low_q       <= '0;
      phase_q     <= 1'b0;
      arm_q       <= 1'b0;
      idle_cnt_q  <= '0;
      word_pend_q <= 1'b0;
      word_new_q  <= '0;
      frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      word_pend_q <= 1'b0;
      if (read_en) frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (rx && warm_q[1]) arm_q <= 1'b1;
          if (!rx && arm_q) begin
            state_q    <= ST_START;
            idle_cnt_q <= '0;
          end else if (phase_q && rx) begin
            if (idle_cnt_q == TO_LAST) begin
              phase_q    <= 1'b0;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 32'd1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rx ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
`ifdef RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
`ifdef RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_STOP;
            if (rx != ^shift_q) begin
              par_bad_q   <= 1'b1;
              frame_err_q <= 1'b1;
              phase_q     <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            arm_q   <= rx;
`ifdef RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
            if (!rx) begin
              frame_err_q <= 1'b1;
              phase_q     <= 1'b0;
            end else if (byte_ok) begin
              if (!phase_q) begin
                low_q   <= shift_q;
                phase_q <= 1'b1;
              end else begin
                word_new_q  <= {shift_q, low_q};
                word_pend_q <= 1'b1;
                phase_q     <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output word register with consumer handshake and overrun detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (word_pend_q) begin
      if (word_valid_q && !read_en) begin
        overrun_q <= 1'b1;
      end else begin
        word_out_q   <= word_new_q;
        word_valid_q <= 1'b1;
      end
    end else if (read_en) begin
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_receive_decoder.sv
// tb/tb_receive_decoder.sv - directed self-checking bench for receive_decoder (CLKS_PER_BIT=4)
module tb_receive_decoder;

  localparam int CPB = 4;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_in;
  logic        read_en;
  logic [15:0] word_out;
  logic        word_valid;
  logic        rx_active;
  logic        frame_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  receive_decoder #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT_BITS(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .read_en    (read_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .rx_active  (rx_active),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
    serial_in = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic read_pulse();
    read_en = 1'b1;
    step();
    read_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    read_en = 1'b0;
    repeat (3) step();
    chk("reset_word", word_out, 16'h0000);
    chk("reset_flags", {12'h0, word_valid, rx_active, frame_err, overrun}, 16'h0000);
    rst = 1'b0;
    repeat (5) step();

    // 0x34 then 0x12, latency exactly one cycle after stop sample
    send_byte(8'h34);
    send_byte(8'h12);
    step();
    chk("lat_valid_early", word_valid, 1'b0);
    step();
    chk("lat_valid", word_valid, 1'b1);
    chk("word_1234", word_out, 16'h1234);
    chk("flags_1234", {frame_err, overrun}, 2'b00);
    read_pulse();
    chk("read_clears_valid", word_valid, 1'b0);

    // overrun: BEEF unread, then a second word arrives
    send_byte(8'hEF);
    send_byte(8'hBE);
    step(); step();
    chk("word_beef", word_out, 16'hBEEF);
    send_byte(8'h0D);
    send_byte(8'hF0);
    step(); step();
    chk("ovr_word_kept", word_out, 16'hBEEF);
    chk("ovr_flag", {word_valid, overrun}, 2'b11);
    read_pulse();
    chk("ovr_read", {word_valid, overrun, frame_err}, 3'b000);

    // one-cycle glitch is ignored
    serial_in = 1'b0;
    step();
    serial_in = 1'b1;
    step(); step();
    chk("glitch_active", rx_active, 1'b1);
    repeat (10) step();
    chk("glitch_idle", {rx_active, frame_err, word_valid}, 3'b000);
    send_byte(8'h55);
    send_byte(8'hAA);
    step(); step();
    chk("word_aa55", word_out, 16'hAA55);
    read_pulse();

    // bad stop bit drops the byte and sets frame_err
    send_frame(8'h77, 1'b0, ^8'h77);
    repeat (8) step();
    chk("ferr_set", {frame_err, word_valid}, 2'b10);
    send_byte(8'h11);
    send_byte(8'h22);
    step(); step();
    chk("word_2211", word_out, 16'h2211);
    chk("ferr_sticky", frame_err, 1'b1);
    read_pulse();
    chk("ferr_cleared", {frame_err, word_valid}, 2'b00);

    // idle gap shorter than timeout keeps the low byte
    send_byte(8'h34);
    repeat (60) step();
    send_byte(8'h12);
    step(); step();
    chk("short_gap_word", word_out, 16'h1234);
    read_pulse();

    // idle gap longer than timeout discards the low byte
    send_byte(8'h34);
    repeat (100) step();
    send_byte(8'h56);
    send_byte(8'h78);
    step(); step();
    chk("timeout_word", word_out, 16'h7856);
    chk("timeout_flags", {word_valid, frame_err, overrun}, 3'b100);
    read_pulse();

    // asynchronous reset in the middle of the high byte's data bits
    send_byte(8'h99);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    chk("pre_reset_active", rx_active, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_word", word_out, 16'h0000);
    chk("async_reset_flags", {12'h0, word_valid, rx_active, frame_err, overrun}, 16'h0000);
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    serial_in = 1'b1;
    repeat (6) step();
    chk("post_reset_idle", rx_active, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    step(); step();
    chk("word_0201", word_out, 16'h0201);
    read_pulse();

`ifdef RX_PARITY_EN
    // even parity: wrong parity drops byte, right parity accepted
    send_frame(8'h03, 1'b1, 1'b1);
    step(); step();
    chk("par_err", {frame_err, word_valid}, 2'b10);
    read_pulse();
    send_frame(8'h03, 1'b1, 1'b0);
    send_byte(8'h04);
    step(); step();
    chk("par_word", word_out, 16'h0403);
    chk("par_flags", {word_valid, frame_err}, 2'b10);
    read_pulse();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
